// File: rtl/output_io_ser.sv
// output_io_ser
//   Output-direction pad cell. It takes parallel words from the fabric over a
//   valid/ready handshake and shifts them out LSB first onto a registered pad
//   output, with a registered output enable. In "out_reg" mode it acts as a
//   plain 1-bit registered output with no serialization.
//
// Parameters
//   MODE       "out_ser" (serializer) or "out_reg" (1-bit registered output)
//   WIDTH      word width in out_ser mode, legal range 2..8
//   IDLE_LEVEL PAD_O level while no word is being shifted
//
// Ports
//   IQC        in   fabric clock, all state on the rising edge
//   QRT_N      in   asynchronous active-low reset
//   F2A_DATA   in   word to transmit, bit 0 goes out first
//   F2A_VALID  in   F2A_DATA is valid
//   F2A_READY  out  cell accepts a word on this cycle's rising edge
//   F2A_OE     in   requested pad output enable
//   PAD_O      out  registered pad data
//   PAD_OE     out  registered pad output enable
//   BUSY       out  a word is currently being shifted (state == SHIFT)
//
// Handshake: a word is transferred on a rising edge of IQC where
// F2A_VALID && F2A_READY. F2A_READY never depends on F2A_VALID, and a
// word held with F2A_VALID high while F2A_READY is low is neither taken
// nor lost; it goes on the next edge where F2A_READY is high.
module output_io_ser #(
  parameter string MODE       = "out_ser",
  parameter int    WIDTH      = 4,
  parameter logic  IDLE_LEVEL = 1'b0
) (
  input  logic             IQC,
  input  logic             QRT_N,
  input  logic [WIDTH-1:0] F2A_DATA,
  input  logic             F2A_VALID,
  output logic             F2A_READY,
  input  logic             F2A_OE,
  output logic             PAD_O,
  output logic             PAD_OE,
  output logic             BUSY
);

  localparam bit              IS_SER   = (MODE == "out_ser");
  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             r_pad_o;
  logic             w_pad_o_nxt;
  logic             r_pad_oe;
  logic             w_pad_oe_nxt;
  logic             w_ready;
  logic             w_accept;
  logic             w_last_bit;

  // The last bit of the current word is on the pad; this is the only cycle
  // during SHIFT in which a new word may be taken.
  assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);

  // READY is forced low while reset is held so nothing upstream believes a
  // word was taken by a cell that is being cleared.
  always_comb begin
    w_ready = 1'b0;
    if (QRT_N) begin
      if (!IS_SER) begin
        w_ready = 1'b1;
      end else begin
        w_ready = (r_state == ST_IDLE) || w_last_bit;
      end
    end
  end

  assign w_accept = F2A_VALID && w_ready;

  // Next-state / datapath logic. Defaults hold every register.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_pad_o_nxt  = r_pad_o;
    w_pad_oe_nxt = r_pad_oe;

    if (!IS_SER) begin
      // Registered pass-through: state, counter and shifter stay idle.
      if (w_accept) begin
        w_pad_o_nxt  = F2A_DATA[0];
        w_pad_oe_nxt = F2A_OE;
      end
    end else begin
      if (w_accept) begin
        // Load path shared by IDLE and the last-bit cycle of SHIFT, which
        // gives back-to-back words with no idle bit in between.
        w_state_nxt  = ST_SHIFT;
        w_cnt_nxt    = '0;
        w_shift_nxt  = F2A_DATA;
        w_pad_o_nxt  = F2A_DATA[0];
        w_pad_oe_nxt = F2A_OE;
      end else if (r_state == ST_IDLE || w_last_bit) begin
        // Idle (or word finished with nothing queued): pad rests at the
        // idle level and OE tracks the request one cycle late.
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = '0;
        w_pad_o_nxt  = IDLE_LEVEL;
        w_pad_oe_nxt = F2A_OE;
      end else begin
        // Mid-word: shift right so the next bit is always at index 1.
        // OE is deliberately held at the value captured on accept.
        w_cnt_nxt   = r_cnt + CW'(1);
        w_shift_nxt = r_shift >> 1;
        w_pad_o_nxt = r_shift[1];
      end
    end
  end

  always_ff @(posedge IQC or negedge QRT_N) begin
    if (!QRT_N) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_pad_o  <= IDLE_LEVEL;
      r_pad_oe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_pad_o  <= w_pad_o_nxt;
      r_pad_oe <= w_pad_oe_nxt;
    end
  end

  assign F2A_READY = w_ready;
  assign PAD_O     = r_pad_o;
  assign PAD_OE    = r_pad_oe;
  assign BUSY      = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_output_io_ser.sv
// Bench for output_io_ser: one out_ser instance (WIDTH=4, IDLE_LEVEL=0) and
// one out_reg instance share the clock and reset. Inputs are driven and
// outputs sampled on the falling edge; the rising edge is the active edge.
// Expected per-cycle tuples {PAD_O, PAD_OE, F2A_READY, BUSY} are queued
// from hand-computed tables and drained one per cycle.
module tb_output_io_ser;

  logic       clk;
  logic       rst_n;

  logic [3:0] s_data;
  logic       s_valid;
  logic       s_oe;
  logic       s_ready;
  logic       s_pad_o;
  logic       s_pad_oe;
  logic       s_busy;

  logic [3:0] g_data;
  logic       g_valid;
  logic       g_oe;
  logic       g_ready;
  logic       g_pad_o;
  logic       g_pad_oe;
  logic       g_busy;

  int n_total;
  int n_bad;

  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  output_io_ser #(.MODE("out_ser"), .WIDTH(4), .IDLE_LEVEL(1'b0)) u_ser (
    .IQC       (clk),
    .QRT_N     (rst_n),
    .F2A_DATA  (s_data),
    .F2A_VALID (s_valid),
    .F2A_READY (s_ready),
    .F2A_OE    (s_oe),
    .PAD_O     (s_pad_o),
    .PAD_OE    (s_pad_oe),
    .BUSY      (s_busy)
  );

  output_io_ser #(.MODE("out_reg"), .WIDTH(4), .IDLE_LEVEL(1'b0)) u_reg (
    .IQC       (clk),
    .QRT_N     (rst_n),
    .F2A_DATA  (g_data),
    .F2A_VALID (g_valid),
    .F2A_READY (g_ready),
    .F2A_OE    (g_oe),
    .PAD_O     (g_pad_o),
    .PAD_OE    (g_pad_oe),
    .BUSY      (g_busy)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: wait for the falling edge, pop the next expected tuple and
  // compare it against the selected instance.
  task automatic cyc_check(input string tag, input bit use_reg);
    logic [3:0] e;
    logic [3:0] got;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, " queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      if (use_reg) got = {g_pad_o, g_pad_oe, g_ready, g_busy};
      else         got = {s_pad_o, s_pad_oe, s_ready, s_busy};
      chk(tag, {28'd0, got}, {28'd0, e});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;

    // Reset held with a full-ones word presented on both instances.
    rst_n   = 1'b0;
    s_data  = 4'hF; s_valid = 1'b1; s_oe = 1'b1;
    g_data  = 4'hF; g_valid = 1'b1; g_oe = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst ser tuple", {28'd0, s_pad_o, s_pad_oe, s_ready, s_busy}, 32'h0);
    chk("rst reg tuple", {28'd0, g_pad_o, g_pad_oe, g_ready, g_busy}, 32'h0);

    // Release mid low-phase: READY must rise before any edge.
    s_valid = 1'b0;
    g_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("rel ser ready", {31'd0, s_ready}, 32'd1);
    chk("rel reg ready", {31'd0, g_ready}, 32'd1);
    // Idle: OE tracks request (1), pad at idle level.
    exp_q.push_back(4'b0110);
    cyc_check("idle ser", 1'b0);

    // Single word 1011, OE=1: pad 1,1,0,1 then idle.
    s_data = 4'b1011; s_valid = 1'b1; s_oe = 1'b1;
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0110);
    for (int i = 0; i < 5; i++) begin
      cyc_check($sformatf("single c%0d", i), 1'b0);
      if (i == 0) s_valid = 1'b0;
    end

    // Back-to-back 0001 then 1110 with VALID held high.
    s_data = 4'b0001; s_valid = 1'b1;
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0110);
    for (int i = 0; i < 9; i++) begin
      cyc_check($sformatf("b2b c%0d", i), 1'b0);
      if (i == 0) s_data = 4'b1110;
      if (i == 7) s_valid = 1'b0;
    end

    // Stall: 0110 in flight, 4'hA offered while READY low; OE request
    // drops mid-word and must only apply to the second word.
    s_data = 4'b0110; s_valid = 1'b1; s_oe = 1'b1;
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1011);
    exp_q.push_back(4'b0010);
    for (int i = 0; i < 9; i++) begin
      cyc_check($sformatf("stall c%0d", i), 1'b0);
      if (i == 0) s_data = 4'hA;
      if (i == 1) s_oe = 1'b0;
      if (i == 7) s_valid = 1'b0;
    end
    s_oe = 1'b1;

    // Mid-word reset after two bits of 1111.
    s_data = 4'b1111; s_valid = 1'b1;
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1101);
    for (int i = 0; i < 2; i++) begin
      cyc_check($sformatf("mwr c%0d", i), 1'b0);
      if (i == 0) s_valid = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mwr async tuple", {28'd0, s_pad_o, s_pad_oe, s_ready, s_busy}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("mwr rel tuple", {28'd0, s_pad_o, s_pad_oe, s_ready, s_busy}, 32'b0010);
    exp_q.push_back(4'b0110);
    cyc_check("mwr idle", 1'b0);

    // Clean restart with 0101: pad 1,0,1,0 then idle.
    s_data = 4'b0101; s_valid = 1'b1;
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b0110);
    for (int i = 0; i < 5; i++) begin
      cyc_check($sformatf("restart c%0d", i), 1'b0);
      if (i == 0) s_valid = 1'b0;
    end

    // out_reg: held at reset values since VALID has been low.
    exp_q.push_back(4'b0010);
    cyc_check("oreg hold0", 1'b1);
    g_valid = 1'b1; g_data = 4'b0001; g_oe = 1'b1;
    exp_q.push_back(4'b1110);
    cyc_check("oreg v1", 1'b1);
    g_data = 4'b0000; g_oe = 1'b1;
    exp_q.push_back(4'b0110);
    cyc_check("oreg v2", 1'b1);
    g_data = 4'b0001; g_oe = 1'b0;
    exp_q.push_back(4'b1010);
    cyc_check("oreg v3", 1'b1);
    g_valid = 1'b0; g_data = 4'b0000; g_oe = 1'b1;
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b1010);
    cyc_check("oreg hold1", 1'b1);
    cyc_check("oreg hold2", 1'b1);

    chk("queue drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/output_io_ser.md
# output_io_ser

Output-direction I/O cell for the AP3 fabric: accepts parallel words from the fabric over a valid/ready handshake and serializes them, LSB first, onto a single registered pad output with a registered output enable. It is the fabric-to-pad counterpart of the input pad path: data flows fabric → cell → pad. It supports a pass-through registered mode for single-bit outputs. It sits at the pad boundary; PAD_O/PAD_OE connect directly to the output pad driver.

## Interface
- MODE, "out_ser": "out_ser" (serializer) or "out_reg" (1-bit registered output, no serialization)
- WIDTH, 4: word width in out_ser mode, legal 2..8
- IDLE_LEVEL, 1'b0: PAD_O level when no word is being shifted
---
- IQC  in  1  fabric clock (CLOCK), all state on rising edge
- QRT_N  in  1  reset, asynchronous, active-low
- F2A_DATA  in  WIDTH  word to transmit, bit 0 sent first
- F2A_VALID  in  1  F2A_DATA valid
- F2A_READY  out  1  cell can accept a word this cycle
- F2A_OE  in  1  requested output enable
- PAD_O  out  1  registered pad data
- PAD_OE  out  1  registered pad output enable
- BUSY  out  1  word currently being shifted

## Operation
- Reset (QRT_N low, asynchronous): state IDLE, shift register and bit counter cleared, PAD_O=IDLE_LEVEL, PAD_OE=0, BUSY=0, F2A_READY=0 while QRT_N low.
- Accept: a word is accepted on a rising edge where F2A_VALID & F2A_READY; otherwise F2A_DATA is ignored.
- out_ser states:
  - IDLE: F2A_READY=1. On accept → SHIFT, load the shift register, PAD_O<=F2A_DATA[0], PAD_OE<=F2A_OE, counter<=0. Without accept: PAD_O<=IDLE_LEVEL, PAD_OE<=F2A_OE (registered tracking).
  - SHIFT: each edge counter+1 and PAD_O<=next bit. F2A_READY=1 only when counter==WIDTH-1 (last bit on pad). At that edge:
    - With accept: new word loads and its bit 0 follows with no gap. Stay in SHIFT. PAD_OE<=new F2A_OE.
    - Without accept: → IDLE, PAD_O<=IDLE_LEVEL, PAD_OE<=F2A_OE.
  - PAD_OE is held constant for a whole word, using the value captured at accept. F2A_OE changes mid-word are ignored.
- BUSY = (state==SHIFT). F2A_READY is combinational from state and counter.
- out_reg mode:
  - F2A_READY=1 whenever out of reset.
  - On edge with F2A_VALID: PAD_O<=F2A_DATA[0], PAD_OE<=F2A_OE. Otherwise both hold.
  - BUSY=0. The counter and shift register are unused.
- Counter width is ceil(log2(WIDTH)). It never exceeds WIDTH-1 and wraps to 0 only on a back-to-back load.

## Timing
- Latency: accept at edge k → bit i on PAD_O from edge k+i to edge k+i+1, for i=0..WIDTH-1.
- Back-to-back throughput: one word per WIDTH cycles, with no idle bit between words.
- Non-back-to-back: PAD_O returns to IDLE_LEVEL at edge k+WIDTH.
- F2A_READY deasserted during SHIFT except on the last-bit cycle. VALID held while READY low produces no effect and no loss; the word is taken on the next READY cycle.
- Reset asserted mid-word: the word is dropped and outputs go to reset values immediately (not at the next edge). After QRT_N rises, the first edge may accept.
- out_reg: PAD_O/PAD_OE are 1-cycle registered copies.

## Test plan
- Reset: QRT_N=0 with VALID=1 and DATA=4'hF → PAD_O=0, PAD_OE=0, READY=0, BUSY=0. Release reset → READY=1 before the first edge.
- Single word: WIDTH=4, accept 4'b1011 with OE=1 → PAD_O=1,1,0,1 on cycles k..k+3 with PAD_OE=1; at k+4 PAD_O=0 and BUSY=0.
- Back-to-back: 4'b0001 then 4'b1110, with VALID held high → PAD_O=1,0,0,0,0,1,1,1 contiguous. READY pulses high only on cycles k+3 and k+7.
- Stall: VALID high with 4'hA during SHIFT (READY low) → word not taken until the last-bit cycle. PAD_O then shows 0,1,0,1 with no corruption of the current word.
- Mid-word reset: after 2 bits of 4'b1111, pulse QRT_N low for 1 ns → PAD_O=0 and PAD_OE=0 immediately. The next accepted word 4'b0101 starts cleanly at bit 0.
- out_reg mode: VALID=1 with DATA[0] sequence 1,0,1 and OE 1,1,0 → PAD_O/PAD_OE follow 1 cycle later. With VALID=0, both hold their last values.
